ifu_fetch: RTL and testbench

Instruction fetch front end for the single-issue RV32 core. It owns the fetch program counter and issues word reads to instruction memory over a req/gnt/rvalid interface. Returned instructions are buffered in a small FIFO and presented to decode over a valid/ready handshake. Branch and jump redirects from execute flush the FIFO, and any in-flight responses to the stale address are discarded.

---
 rtl/ifu_fetch.sv | 119 +++++++++++
 tb/tb_ifu_fetch.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch front end: owns the fetch PC, issues single-outstanding word reads
// to instruction memory and buffers returned instructions in a small FIFO for decode.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] pc;
   } entry_t;

   state_t          state, state_nxt;
   logic [31:0]     fetch_pc, fetch_pc_nxt;
   logic [31:0]     req_pc;
   logic            drop, drop_nxt;
   entry_t          mem [DEPTH];
   logic [AW-1:0]   rd_ptr, wr_ptr;
   logic [CW-1:0]   count, count_nxt;
   logic            push, pop;

   assign inst_valid = (count != '0);
   assign pop        = inst_valid & inst_ready;
   // A redirect on the same edge discards the returning word along with the FIFO.
   assign push       = (state == S_WAIT) & imem_rvalid & ~drop & ~redirect_valid;
   assign count_nxt  = count + CW'(push) - CW'(pop);

   assign imem_req  = (state == S_REQ) & ~rst;
   assign imem_addr = fetch_pc;
   assign inst      = mem[rd_ptr].word;
   assign inst_pc   = mem[rd_ptr].pc;

   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      drop_nxt     = drop;
      case (state)
         S_IDLE: if (count < CW'(DEPTH)) state_nxt = S_REQ;
         S_REQ: begin
            if (imem_gnt) begin
               fetch_pc_nxt = fetch_pc + 32'd4;
               state_nxt    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               drop_nxt  = 1'b0;
               state_nxt = (count_nxt < CW'(DEPTH)) ? S_REQ : S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      // Redirect overrides the fetch address; an in-flight read is marked stale.
      if (redirect_valid) begin
         fetch_pc_nxt = {redirect_pc[31:2], 2'b00};
         case (state)
            S_IDLE:  state_nxt = S_REQ;
            S_REQ:   if (imem_gnt) drop_nxt = 1'b1;
            S_WAIT: begin
               if (imem_rvalid) state_nxt = S_REQ;
               else             drop_nxt  = 1'b1;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_REQ;
         fetch_pc <= RESET_PC;
         req_pc   <= RESET_PC;
         drop     <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         // NOTE: the FIFO storage is reset so inst/inst_pc read as zero out of reset.
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
         drop     <= drop_nxt;
         if (state == S_REQ && imem_gnt) req_pc <= fetch_pc;
         if (redirect_valid) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            count <= count_nxt;
            if (push) begin
               mem[wr_ptr] <= '{word: imem_rdata, pc: req_pc};
               wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
         end
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: a bench-side memory model grants and returns words,
// expected instructions are queued on return and compared when decode pops them.
module tb_ifu_fetch;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   always #5 clk = ~clk;

   ifu_fetch #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
      int          gcyc;
   } exp_t;

   exp_t        expq[$];
   int          n_checks = 0;
   int          n_err    = 0;
   int          cyc      = 0;
   bit          ready, redir_req, redir_on_gnt, redir_on_rv, force_rv, check_lat;
   bit          out_valid, out_drop;
   logic [31:0] redir_target, exp_pc, out_addr, last_gnt_addr;
   int          gnt_stall, rv_delay, age, stall_cnt, out_cyc, n_gnt, last_gnt_cyc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // One clock: sample outputs at the falling edge, drive inputs, update the model.
   task automatic step();
      bit   g, rv;
      exp_t e;
      @(negedge clk);
      cyc++;
      g  = 1'b0;
      rv = 1'b0;
      if (out_valid) begin
         age++;
         if (age >= rv_delay) rv = 1'b1;
         check("req_while_busy", {31'b0, imem_req}, 32'd0);
      end
      if (force_rv) rv = 1'b1;
      else if (imem_req && !out_valid) begin
         if (stall_cnt >= gnt_stall) g = 1'b1;
         else begin
            check("stall_addr", imem_addr, exp_pc);
            stall_cnt++;
         end
      end
      if (redir_on_gnt && g) begin redir_req = 1'b1; redir_on_gnt = 1'b0; end
      if (redir_on_rv && rv && out_valid) begin redir_req = 1'b1; redir_on_rv = 1'b0; end

      imem_gnt       = g;
      imem_rvalid    = rv;
      imem_rdata     = (rv && out_valid) ? mem_word(out_addr) : 32'hDEAD_BEEF;
      inst_ready     = ready;
      redirect_valid = redir_req;
      redirect_pc    = redir_target;

      if (inst_valid && ready) begin
         if (expq.size() == 0) check("unexpected_inst", {31'b0, inst_valid}, 32'd0);
         else begin
            e = expq.pop_front();
            check("inst_pc", inst_pc, e.pc);
            check("inst", inst, e.word);
            if (check_lat) check("latency", cyc - e.gcyc, 32'd2);
         end
      end
      if (rv && out_valid) begin
         if (!out_drop && !redir_req) begin
            e.pc = out_addr; e.word = mem_word(out_addr); e.gcyc = out_cyc;
            expq.push_back(e);
         end
         out_valid = 1'b0;
      end
      if (g) begin
         check("gnt_addr", imem_addr, exp_pc);
         if (check_lat && n_gnt > 0) check("req_spacing", cyc - last_gnt_cyc, 32'd2);
         last_gnt_cyc  = cyc;
         last_gnt_addr = imem_addr;
         out_valid     = 1'b1;
         out_addr      = exp_pc;
         out_drop      = redir_req;
         out_cyc       = cyc;
         age           = 0;
         stall_cnt     = 0;
         n_gnt++;
         exp_pc        = exp_pc + 32'd4;
      end
      if (redir_req) begin
         expq.delete();
         if (out_valid) out_drop = 1'b1;
         exp_pc    = redir_target & ~32'd3;
         redir_req = 1'b0;
      end
      force_rv = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_gnt(input string tag, input logic [31:0] exp_addr);
      int start;
      start = n_gnt;
      for (int i = 0; i < 40 && n_gnt == start; i++) step();
      check({tag, "_granted"}, n_gnt - start, 32'd1);
      if (n_gnt != start) check(tag, last_gnt_addr, exp_addr);
   endtask

   task automatic wait_outstanding();
      for (int i = 0; i < 40 && !out_valid; i++) step();
      check("outstanding_seen", {31'b0, out_valid}, 32'd1);
   endtask

   task automatic do_reset();
      imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
      imem_rdata = 32'h0; redirect_pc = 32'h0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_req", {31'b0, imem_req}, 32'd0);
      check("rst_addr", imem_addr, RESET_PC);
      check("rst_valid", {31'b0, inst_valid}, 32'd0);
      check("rst_inst", inst, 32'd0);
      check("rst_inst_pc", inst_pc, 32'd0);
      expq.delete();
      out_valid = 1'b0; out_drop = 1'b0; redir_req = 1'b0; redir_on_gnt = 1'b0;
      redir_on_rv = 1'b0; force_rv = 1'b0; stall_cnt = 0; n_gnt = 0;
      exp_pc = RESET_PC;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      ready = 1'b1; check_lat = 1'b0; gnt_stall = 0; rv_delay = 1; redir_target = 32'h0;

      // Streaming fetch with single-cycle memory and an always-ready decoder.
      do_reset();
      ready = 1'b1; check_lat = 1'b1;
      step();
      check("req_after_rst", {31'b0, imem_req}, 32'd1);
      check("first_gnt_addr", last_gnt_addr, RESET_PC);
      wait_gnt("seq_a1", 32'h8000_0004);
      wait_gnt("seq_a2", 32'h8000_0008);
      run(4);
      check_lat = 1'b0;

      // Decoder stalled: FIFO fills with two words, then drains in order.
      do_reset();
      ready = 1'b0;
      run(20);
      check("full_gnts", n_gnt, 32'd2);
      check("full_req", {31'b0, imem_req}, 32'd0);
      check("full_valid", {31'b0, inst_valid}, 32'd1);
      check("full_head_pc", inst_pc, 32'h8000_0000);
      check("full_queue", expq.size(), 32'd2);
      ready = 1'b1;
      wait_gnt("resume_addr", 32'h8000_0008);
      run(4);

      // Redirect while waiting for a slow response.
      rv_delay = 4;
      wait_outstanding();
      redir_target = 32'h8000_1002; redir_req = 1'b1;
      step();
      wait_gnt("redir_wait_addr", 32'h8000_1000);
      rv_delay = 1;
      run(6);

      // Redirect coinciding with a grant, then with a response.
      redir_target = 32'h8000_2000; redir_on_gnt = 1'b1;
      for (int i = 0; i < 40 && redir_on_gnt; i++) step();
      wait_gnt("redir_gnt_addr", 32'h8000_2000);
      run(3);
      redir_target = 32'h8000_3000; redir_on_rv = 1'b1;
      for (int i = 0; i < 40 && redir_on_rv; i++) step();
      wait_gnt("redir_rv_addr", 32'h8000_3000);
      run(5);

      // Memory withholds the grant for five cycles.
      gnt_stall = 5;
      run(2);
      wait_gnt("stall_gnt", exp_pc);
      gnt_stall = 0;
      run(4);

      // Fetch address wraps past the top of the address space.
      redir_target = 32'hFFFF_FFFC; redir_req = 1'b1;
      step();
      wait_gnt("wrap_top", 32'hFFFF_FFFC);
      wait_gnt("wrap_zero", 32'h0000_0000);
      run(4);

      // Reset in the middle of an outstanding read; a late response must be ignored.
      rv_delay = 3;
      wait_outstanding();
      do_reset();
      rv_delay = 1;
      force_rv = 1'b1;
      step();
      check("post_rst_addr", imem_addr, RESET_PC);
      check("post_rst_req", {31'b0, imem_req}, 32'd1);
      step();
      check("stale_rv_ignored", {31'b0, inst_valid}, 32'd0);
      check("post_rst_gnt", last_gnt_addr, RESET_PC);
      run(6);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
